// File: rtl/seg7_share_arbiter.sv
// Round-robin arbiter sharing one external 3-bit-to-7-segment decoder among
// N_DISP requesters; each grant captures the decoded byte into that display's register.
module seg7_share_arbiter #(
  parameter int unsigned N_DISP = 6,
  parameter int unsigned PTR_W  = 3
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [N_DISP-1:0]     req,
  input  logic [3*N_DISP-1:0]   val,
  input  logic [N_DISP-1:0]     blank,
  input  logic                  clear,
  output logic [2:0]            dec_in,
  input  logic [7:0]            dec_out,
  output logic [8*N_DISP-1:0]   hex,
  output logic [N_DISP-1:0]     ack,
  output logic                  busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CAPT = 2'd1,
    ACK  = 2'd2
  } state_t;

  state_t                state_q, state_d;
  logic [PTR_W-1:0]      ptr_q, ptr_d;
  logic [PTR_W-1:0]      grant_q, grant_d;
  logic [2:0]            dec_d;
  logic                  blank_q, blank_d;
  logic [8*N_DISP-1:0]   hex_d;
  logic [N_DISP-1:0]     ack_d;

  logic                  found;
  logic [PTR_W-1:0]      pick;
  logic [PTR_W-1:0]      idx;

  // First requesting index at or after ptr, wrapping modulo N_DISP (not 2^PTR_W).
  always_comb begin
    found = 1'b0;
    pick  = '0;
    idx   = '0;
    for (int unsigned k = 0; k < N_DISP; k++) begin
      idx = PTR_W'((32'(ptr_q) + k) % N_DISP);
      if (!found && req[idx]) begin
        found = 1'b1;
        pick  = idx;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    grant_d = grant_q;
    dec_d   = dec_in;
    blank_d = blank_q;
    hex_d   = hex;
    ack_d   = '0;
    case (state_q)
      IDLE: begin
        if (clear) begin
          hex_d = '1;
        end else if (found) begin
          grant_d = pick;
          dec_d   = val[3*pick +: 3];
          blank_d = blank[pick];
          state_d = CAPT;
        end
      end
      CAPT: begin
        hex_d[8*grant_q +: 8] = blank_q ? 8'hFF : dec_out;
        ack_d[grant_q]        = 1'b1;
        ptr_d                 = (grant_q == PTR_W'(N_DISP - 1)) ? '0 : grant_q + 1'b1;
        state_d               = ACK;
      end
      ACK: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      grant_q <= '0;
      dec_in  <= '0;
      blank_q <= 1'b0;
      hex     <= '1;
      ack     <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      grant_q <= grant_d;
      dec_in  <= dec_d;
      blank_q <= blank_d;
      hex     <= hex_d;
      ack     <= ack_d;
    end
  end

  assign busy = (state_q != IDLE);

endmodule

// File: tb/tb_seg7_share_arbiter.sv
// Scoreboard bench for seg7_share_arbiter: expected (display, byte) pairs are
// queued as requests are driven and retired on each ack pulse.
module tb_seg7_share_arbiter;

  localparam int unsigned N = 6;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             clear = 1'b0;
  logic [N-1:0]     req   = '0;
  logic [N-1:0]     blank = '0;
  logic [3*N-1:0]   val   = '0;
  logic [2:0]       dec_in;
  logic [7:0]       dec_out;
  logic [8*N-1:0]   hex;
  logic [N-1:0]     ack;
  logic             busy;

  int errors = 0;
  int checks = 0;

  typedef struct {
    int unsigned idx;
    logic [7:0]  byte_v;
  } exp_t;

  exp_t       sbq[$];
  logic [7:0] exp_hex [N];

  always #5 clk = ~clk;

  // Active-low common-anode patterns, DP off.
  function automatic logic [7:0] seg(input logic [2:0] c);
    case (c)
      3'd0: return 8'hC0;
      3'd1: return 8'hF9;
      3'd2: return 8'hA4;
      3'd3: return 8'hB0;
      3'd4: return 8'h99;
      3'd5: return 8'h92;
      3'd6: return 8'h82;
      default: return 8'hF8;
    endcase
  endfunction

  assign dec_out = seg(dec_in);

  seg7_share_arbiter #(
    .N_DISP(N),
    .PTR_W (3)
  ) dut (
    .clk    (clk),
    .reset  (reset),
    .req    (req),
    .val    (val),
    .blank  (blank),
    .clear  (clear),
    .dec_in (dec_in),
    .dec_out(dec_out),
    .hex    (hex),
    .ack    (ack),
    .busy   (busy)
  );

  function automatic logic [8*N-1:0] model_hex();
    logic [8*N-1:0] v;
    v = '0;
    for (int i = 0; i < N; i++) v[8*i +: 8] = exp_hex[i];
    return v;
  endfunction

  task automatic model_blank_all();
    for (int i = 0; i < N; i++) exp_hex[i] = 8'hFF;
  endtask

  // Scoreboard: every ack pulse retires the oldest expected transaction.
  always @(negedge clk) begin : monitor
    exp_t           e;
    logic [N-1:0]   eack;
    logic [8*N-1:0] ehex;
    if (ack !== '0) begin
      checks++;
      if (sbq.size() == 0) begin
        errors++;
        $display("FAIL unexpected_ack: ack=%b with no transaction expected", ack);
      end else begin
        e    = sbq.pop_front();
        eack = N'(1) << e.idx;
        if (ack !== eack) begin
          errors++;
          $display("FAIL ack_grant: ack=%b expected %b", ack, eack);
        end
        exp_hex[e.idx] = e.byte_v;
        ehex = model_hex();
        checks++;
        if (hex !== ehex) begin
          errors++;
          $display("FAIL hex_capture: hex=%h expected %h (display %0d)", hex, ehex, e.idx);
        end
      end
    end
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic apply_reset();
    reset = 1'b1;
    req   = '0;
    clear = 1'b0;
    blank = '0;
    tick();
    tick();
    reset = 1'b0;
    model_blank_all();
    sbq.delete();
  endtask

  task automatic drain(input int budget);
    int n;
    n = 0;
    while (sbq.size() != 0 && n < budget) begin
      tick();
      req &= ~ack;
      n++;
    end
    if (sbq.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout: %0d transactions outstanding after %0d cycles, required 0",
               sbq.size(), budget);
      sbq.delete();
    end
    tick();
  endtask

  task automatic test_reset();
    logic [8*N+N+1+3-1:0] expv;
    expv = {{N{8'hFF}}, {N{1'b0}}, 1'b0, 3'b000};
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    model_blank_all();
    for (int i = 0; i < 10; i++) begin
      tick();
      checks++;
      if ({hex, ack, busy, dec_in} !== expv) begin
        errors++;
        $display("FAIL reset_idle: cycle %0d hex=%h ack=%b busy=%b dec_in=%0d, required hex all FF, ack 0, busy 0, dec_in 0",
                 i, hex, ack, busy, dec_in);
      end
    end
  endtask

  task automatic test_single();
    val[3*2 +: 3] = 3'd5;
    req[2] = 1'b1;
    sbq.push_back('{2, 8'h92});
    tick();
    checks++;
    if (dec_in !== 3'd5 || busy !== 1'b1 || ack !== '0) begin
      errors++;
      $display("FAIL single_dec_in: dec_in=%0d busy=%b ack=%b, required 5 1 000000", dec_in, busy, ack);
    end
    tick();
    checks++;
    if (ack !== 6'b000100) begin
      errors++;
      $display("FAIL single_ack: ack=%b required 000100", ack);
    end
    req[2] = 1'b0;
    tick();
    checks++;
    if (busy !== 1'b0 || ack !== '0 || hex !== 48'hFFFF_FF92_FFFF) begin
      errors++;
      $display("FAIL single_done: busy=%b ack=%b hex=%h, required 0 000000 ffffff92ffff", busy, ack, hex);
    end
    checks++;
    if (sbq.size() != 0) begin
      errors++;
      $display("FAIL single_outstanding: %0d left, required 0", sbq.size());
    end
  endtask

  task automatic test_back_to_back();
    int cyc, last, nacks;
    bit re_req;
    apply_reset();
    for (int i = 0; i < N; i++) begin
      val[3*i +: 3] = 3'(i);
      sbq.push_back('{i, seg(3'(i))});
    end
    req = '1;
    cyc = 0; last = -1; nacks = 0; re_req = 1'b0;
    while (nacks < N + 1 && cyc < 60) begin
      tick();
      cyc++;
      if (re_req) begin
        req[0] = 1'b1;
        re_req = 1'b0;
      end
      if (ack !== '0) begin
        if (last >= 0) begin
          checks++;
          if (cyc - last != 3) begin
            errors++;
            $display("FAIL ack_spacing: %0d cycles between acks, required 3", cyc - last);
          end
        end
        last = cyc;
        nacks++;
        if (ack[0] && nacks == 1) begin
          re_req = 1'b1;
          sbq.push_back('{0, 8'hC0});
        end
        req &= ~ack;
      end
    end
    checks++;
    if (nacks != N + 1) begin
      errors++;
      $display("FAIL rr_timeout: %0d acks seen, required %0d", nacks, N + 1);
    end
    tick();
    checks++;
    if (hex !== 48'h9299_B0A4_F9C0) begin
      errors++;
      $display("FAIL rr_hex: hex=%h required 9299b0a4f9c0", hex);
    end
  endtask

  task automatic test_blank();
    checks++;
    if (hex[15:8] !== 8'hF9) begin
      errors++;
      $display("FAIL blank_pre: hex[1]=%h required f9", hex[15:8]);
    end
    blank[1] = 1'b1;
    val[3*1 +: 3] = 3'd7;
    req[1] = 1'b1;
    sbq.push_back('{1, 8'hFF});
    tick();
    checks++;
    if (dec_in !== 3'd7) begin
      errors++;
      $display("FAIL blank_dec_in: dec_in=%0d required 7", dec_in);
    end
    tick();
    checks++;
    if (ack !== 6'b000010 || hex[15:8] !== 8'hFF) begin
      errors++;
      $display("FAIL blank_write: ack=%b hex[1]=%h, required 000010 ff", ack, hex[15:8]);
    end
    req[1] = 1'b0;
    blank[1] = 1'b0;
    tick();
  endtask

  task automatic test_clear();
    val[3*3 +: 3] = 3'd3;
    clear = 1'b1;
    req[3] = 1'b1;
    tick();
    checks++;
    if (hex !== {N{8'hFF}} || ack !== '0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL clear_priority: hex=%h ack=%b busy=%b, required all ff, 000000, 0", hex, ack, busy);
    end
    model_blank_all();
    clear = 1'b0;
    sbq.push_back('{3, 8'hB0});
    tick();
    checks++;
    if (busy !== 1'b1 || dec_in !== 3'd3) begin
      errors++;
      $display("FAIL clear_then_grant: busy=%b dec_in=%0d, required 1 3", busy, dec_in);
    end
    drain(10);
  endtask

  task automatic test_reset_mid();
    val[3*4 +: 3] = 3'd7;
    req[4] = 1'b1;
    tick();
    checks++;
    if (busy !== 1'b1 || dec_in !== 3'd7) begin
      errors++;
      $display("FAIL midrst_capt: busy=%b dec_in=%0d, required 1 7", busy, dec_in);
    end
    reset = 1'b1;
    tick();
    checks++;
    if (ack !== '0 || hex !== {N{8'hFF}} || busy !== 1'b0) begin
      errors++;
      $display("FAIL midrst_abort: ack=%b hex=%h busy=%b, required 000000 all ff 0", ack, hex, busy);
    end
    model_blank_all();
    reset = 1'b0;
    // Requester 1 competes with 4: a pointer reset to 0 serves 1 first.
    val[3*1 +: 3] = 3'd1;
    req[1] = 1'b1;
    sbq.push_back('{1, 8'hF9});
    sbq.push_back('{4, 8'hF8});
    drain(20);
    checks++;
    if (hex !== 48'hFFF8_FFFF_F9FF) begin
      errors++;
      $display("FAIL midrst_final: hex=%h required fff8fffff9ff", hex);
    end
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_blank();
    test_clear();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
